// File: rtl/adat_buf_pkg.sv
// Shared types and constants for the channel_buffer read side.
// Frame geometry (256-bit frame = 8 x 32-bit channel words), default slot
// index width, frame index type and the read-scheduler state encoding.
package adat_buf_pkg;

    localparam int unsigned FRAME_BITS        = 256;
    localparam int unsigned WORD_BITS         = 32;
    localparam int unsigned CHANNELS          = 8;
    localparam int unsigned CIRC_BUF_BITS_DEF = 3;
    localparam int unsigned CHAN_BITS         = $clog2(CHANNELS);
    localparam int unsigned BIT_SEL_BITS      = $clog2(WORD_BITS);

    typedef logic [CIRC_BUF_BITS_DEF-1:0] frame_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/channel_buffer_read_scheduler_if.sv
// Channel-word delivery bus between the read scheduler and its consumer.
//   word_data_o  : channel word, first RAM bit in bit 31
//   word_chan_o  : channel index 0..7
//   word_valid_o : word presented, held until word_ready_i
//   frame_last_o : asserted with the channel-7 word
//   word_ready_i : consumer accepts the word
// master = scheduler side, slave = consumer side.
interface channel_buffer_read_scheduler_if;
    import adat_buf_pkg::*;

    logic [WORD_BITS-1:0] word_data_o;
    logic [CHAN_BITS-1:0] word_chan_o;
    logic                 word_valid_o;
    logic                 frame_last_o;
    logic                 word_ready_i;

    modport master (
        output word_data_o,
        output word_chan_o,
        output word_valid_o,
        output frame_last_o,
        input  word_ready_i
    );

    modport slave (
        input  word_data_o,
        input  word_chan_o,
        input  word_valid_o,
        input  frame_last_o,
        output word_ready_i
    );

endinterface

// File: rtl/frame_fill_tracker.sv
// Tracks completed-but-unread frames in the circular channel buffer.
//   clk, rst_n : clock, async active-low reset
//   running    : receiver stream active
//   last_idx   : index of most recently completed frame
//   accept     : read request taken by the scheduler this cycle
//   fill       : unread complete frames (max 2^N-1)
//   rd_idx     : next slot to read
//   underrun   : pulse, request taken with nothing to read
//   overrun    : pulse, oldest frame dropped on a new completion at full
module frame_fill_tracker #(
    parameter int unsigned CIRC_BUF_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     running,
    input  logic [CIRC_BUF_BITS-1:0] last_idx,
    input  logic                     accept,
    output logic [CIRC_BUF_BITS-1:0] fill,
    output logic [CIRC_BUF_BITS-1:0] rd_idx,
    output logic                     underrun,
    output logic                     overrun
);

    localparam logic [CIRC_BUF_BITS-1:0] IDX_ONE  = CIRC_BUF_BITS'(1);
    localparam logic [CIRC_BUF_BITS-1:0] FILL_MAX = '1;

    logic [CIRC_BUF_BITS-1:0] prev_q, prev_d;
    logic [CIRC_BUF_BITS-1:0] fill_q, fill_d;
    logic [CIRC_BUF_BITS-1:0] rd_q, rd_d;
    logic                     under_d, over_d;
    logic                     new_frame_c, take_c;

    // Fill bookkeeping: completions add, reads remove, full drops the oldest
    always_comb begin
        prev_d      = prev_q;
        fill_d      = fill_q;
        rd_d        = rd_q;
        over_d      = 1'b0;
        new_frame_c = running && (last_idx != prev_q);
        take_c      = accept && (fill_q != '0);
        under_d     = accept && (fill_q == '0);

        if (!running) begin
            prev_d = last_idx;
            fill_d = '0;
            rd_d   = last_idx + IDX_ONE;
        end else begin
            if (new_frame_c) begin
                prev_d = last_idx;
            end
            if (take_c) begin
                rd_d = rd_q + IDX_ONE;
            end
            if (new_frame_c && !take_c) begin
                if (fill_q == FILL_MAX) begin
                    rd_d   = rd_q + IDX_ONE;
                    over_d = 1'b1;
                end else begin
                    fill_d = fill_q + IDX_ONE;
                end
            end else if (take_c && !new_frame_c) begin
                fill_d = fill_q - IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            fill_q   <= '0;
            rd_q     <= IDX_ONE;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            fill_q   <= fill_d;
            rd_q     <= rd_d;
            underrun <= under_d;
            overrun  <= over_d;
        end
    end

    assign fill   = fill_q;
    assign rd_idx = rd_q;

endmodule

// File: rtl/channel_buffer_read_scheduler.sv
// Read-side controller for the channel_buffer circular frame store.
// On request, reads one 256-bit frame bit-serially and delivers it as
// eight 32-bit channel words over a valid/ready bus.
//   clk_x4_i, rst_n_i      : clock, async active-low reset
//   i2s_running_i          : receiver stream active
//   last_good_frame_idx_i  : most recently completed frame slot
//   ram_read_addr_o        : RAM bit address (holds outside LOAD)
//   ram_read_data_i        : RAM bit, one cycle after the address
//   frame_start_i          : request next frame (sampled in IDLE only)
//   word_bus               : channel-word delivery bus (master)
//   fill_level_o           : complete unread frames
//   underrun_o, overrun_o  : event pulses
//   busy_o                 : scheduler not idle
module channel_buffer_read_scheduler
    import adat_buf_pkg::*;
#(
    parameter  int unsigned CIRC_BUF_BITS = CIRC_BUF_BITS_DEF,
    localparam int unsigned ADDR_WIDTH    = CIRC_BUF_BITS + $clog2(FRAME_BITS)
) (
    input  logic                     clk_x4_i,
    input  logic                     rst_n_i,
    input  logic                     i2s_running_i,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    output logic [ADDR_WIDTH-1:0]    ram_read_addr_o,
    input  logic                     ram_read_data_i,
    input  logic                     frame_start_i,
    channel_buffer_read_scheduler_if.master word_bus,
    output logic [CIRC_BUF_BITS-1:0] fill_level_o,
    output logic                     underrun_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int unsigned          CNT_BITS = $clog2(WORD_BITS + 1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_ADDR = CNT_BITS'(WORD_BITS - 1);
    localparam logic [CNT_BITS-1:0]  CNT_DONE = CNT_BITS'(WORD_BITS);
    localparam logic [CHAN_BITS-1:0] CHAN_MAX = CHAN_BITS'(CHANNELS - 1);
    localparam logic [CHAN_BITS-1:0] CHAN_ONE = CHAN_BITS'(1);

    rd_state_e                state_q, state_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;
    logic [CHAN_BITS-1:0]     chan_q, chan_d;
    logic [CIRC_BUF_BITS-1:0] idx_q, idx_d;
    logic                     zero_q, zero_d;
    logic [WORD_BITS-1:0]     word_q, word_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     busy_q, busy_d;

    logic                     accept_c;
    logic [CIRC_BUF_BITS-1:0] fill;
    logic [CIRC_BUF_BITS-1:0] rd_idx;

    assign accept_c = (state_q == IDLE) && frame_start_i;

    frame_fill_tracker #(
        .CIRC_BUF_BITS (CIRC_BUF_BITS)
    ) u_tracker (
        .clk      (clk_x4_i),
        .rst_n    (rst_n_i),
        .running  (i2s_running_i),
        .last_idx (last_good_frame_idx_i),
        .accept   (accept_c),
        .fill     (fill),
        .rd_idx   (rd_idx),
        .underrun (underrun_o),
        .overrun  (overrun_o)
    );

    // Next-state and datapath; {slot, chan, bit} concatenation is base + chan*32 + k
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        word_d  = word_q;
        valid_d = valid_q;
        last_d  = last_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    chan_d  = '0;
                    idx_d   = rd_idx;
                    zero_d  = (fill == '0);
                    addr_d  = {rd_idx, {CHAN_BITS{1'b0}}, {BIT_SEL_BITS{1'b0}}};
                end
            end
            LOAD: begin
                // RAM data trails the address by one cycle, so capture starts at cnt 1
                if (cnt_q != '0) begin
                    word_d = {word_q[WORD_BITS-2:0], ram_read_data_i & ~zero_q};
                end
                if (cnt_q < CNT_ADDR) begin
                    addr_d = {idx_q, chan_q, BIT_SEL_BITS'(cnt_q + CNT_ONE)};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_DONE) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (chan_q == CHAN_MAX);
                end
            end
            HOLD: begin
                if (word_bus.word_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (chan_q == CHAN_MAX) begin
                        state_d = IDLE;
                        zero_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        chan_d  = chan_q + CHAN_ONE;
                        addr_d  = {idx_q, chan_q + CHAN_ONE, {BIT_SEL_BITS{1'b0}}};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
        end
    end

    assign ram_read_addr_o       = addr_q;
    assign word_bus.word_data_o  = word_q;
    assign word_bus.word_chan_o  = chan_q;
    assign word_bus.word_valid_o = valid_q;
    assign word_bus.frame_last_o = last_q;
    assign fill_level_o          = fill;
    assign busy_o                = busy_q;

endmodule

// File: doc/channel_buffer_read_scheduler.md
Name: channel_buffer_read_scheduler

Overview:
Read-side controller for the channel_buffer circular frame store filled by i2s_msb_receiver. It tracks completed frames from last_good_frame_idx, keeps a fill level, and on consumer request reads one 256-bit frame bit-serially through the RAM read port. Each frame is delivered as eight 32-bit channel words over a valid/ready handshake. It sits between channel_buffer and the downstream ADAT/USB framer, and reports underrun and overrun.

Parameters:
CIRC_BUF_BITS, 3, log2 of frame slots in the RAM (must match the receiver)
ADDR_WIDTH, CIRC_BUF_BITS+8, RAM bit-address width (11 by default); derived, not overridden

Ports:
clk_x4_i  in  1  system clock, same as receiver and RAM
rst_n_i  in  1  asynchronous, active-low reset
i2s_running_i  in  1  receiver stream active
last_good_frame_idx_i  in  CIRC_BUF_BITS  index of the most recently completed frame
ram_read_addr_o  out  ADDR_WIDTH  channel_buffer read address
ram_read_data_i  in  1  channel_buffer read data, 1-cycle registered latency
frame_start_i  in  1  consumer request for the next frame (single-cycle pulse)
word_data_o  out  32  channel word, first RAM bit = bit 31
word_chan_o  out  3  channel index 0..7 of word_data_o
word_valid_o  out  1  word_data_o valid
word_ready_i  in  1  consumer accepts the word
frame_last_o  out  1  high with word_valid_o when word_chan_o==7
fill_level_o  out  CIRC_BUF_BITS  complete, unread frames
underrun_o  out  1  one-cycle pulse: request accepted while fill==0
overrun_o  out  1  one-cycle pulse: oldest frame dropped
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (async assert, sync-released by system): all outputs 0; FSM IDLE; rd_idx=1; prev_idx=0; fill=0; zero_mode=0.
- Stream stopped (!i2s_running_i): fill=0, prev_idx tracks last_good_frame_idx_i, rd_idx = last_good_frame_idx_i+1 (mod 2^N). An in-flight frame still completes.
- New frame: running and last_good_frame_idx_i != prev_idx → prev_idx updates; fill+1.
- Maximum fill is 2^N-1, because the slot being written is never readable. At this maximum, a new frame drops the oldest: rd_idx+1, fill unchanged, overrun_o pulses.
- Accept: frame_start_i is sampled only in IDLE; it is ignored otherwise, with no queuing.
  - fill>0: base=rd_idx<<8; rd_idx+1; fill-1.
  - fill==0: underrun_o pulses; zero_mode=1; rd_idx and fill unchanged.
  - Accept coinciding with a new-frame event: net fill unchanged, no overrun.
- FSM states:
  - IDLE → LOAD on accept.
  - LOAD: ram_read_addr_o = base + chan*32 + k for k=0..31, one address per cycle. Captured bit k goes to word bit 31-k. Total 33 cycles including RAM latency. zero_mode still spends 33 cycles but drives word 0.
  - LOAD → HOLD: word_valid_o=1; data and chan are stable until word_ready_i.
  - HOLD on handshake: chan<7 → chan+1, LOAD; chan==7 → IDLE, zero_mode=0.
- Latency: accept at cycle T → first address at T+1 → word_valid_o rises at T+34. This also applies to the next word, counted from the handshake cycle.
- ram_read_addr_o holds its last value outside LOAD.
- Width rules: all index arithmetic is mod 2^CIRC_BUF_BITS, and address arithmetic is mod 2^ADDR_WIDTH. Wrap from slot 7 to slot 0 is seamless.
- Reset mid-frame: immediate abort, no partial word emitted.

Decomposition:
- Shared package adat_buf_pkg:
  - FRAME_BITS=256, WORD_BITS=32, CHANNELS=8.
  - Typedef frame_idx_t.
  - Enum rd_state_e {IDLE, LOAD, HOLD}.
- One sub-module, frame_fill_tracker, containing prev_idx, fill, rd_idx, and the overrun/underrun logic. The FSM and serial-to-parallel shifter stay in the top level.

Test Plan:
- Reset → all outputs 0; fill_level_o=0; busy_o=0; frame_start_i pulse gives underrun_o=1 for one cycle and eight zero words chan 0..7, with frame_last_o only on chan 7.
- Running; last_good_frame_idx_i steps 0→1; RAM slot 1 preloaded with 32'hDEADBEEF,32'h00000001..7 → frame_start_i gives fill 1→0; ram_read_addr_o 256..511; words match in order; word_valid_o at T+34.
- word_ready_i held low 50 cycles at chan 3 → data and chan stable, no address change; release → chan 4 follows 33 cycles later.
- Eight frame completions without reads → fill saturates at 7; eighth completion gives overrun_o pulse; next read starts at slot rd_idx+1.
- rd_idx=7 read then idx 0 → addresses 1792..2047 then 0..255, contiguous data correct.
- rst_n_i low during LOAD of chan 2 → outputs 0 asynchronously; after release a new request behaves as from clean reset.
